// File: rtl/tx_pulse_ch.sv
// Per-channel transmit pulser: LUT-driven focusing delay followed by a bipolar burst.
// Optional macro TX_DAMP_EN adds a return-to-zero clamp phase after the last negative half-cycle.
`timescale 1ns/1ps
module tx_pulse_ch #(
    parameter int unsigned ADDR_WD  = 7,
    parameter int unsigned DELAY_WD = 12,
    parameter int unsigned CYC_WD   = 4,
    parameter int unsigned HP_WD    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_WD-1:0]  lut_addr,
    input  logic                lut_we,
    input  logic [DELAY_WD-1:0] lut_din,
    input  logic [ADDR_WD-1:0]  line_sel,
    input  logic                tx_start,
    input  logic                tx_abort,
    input  logic [CYC_WD-1:0]   num_cycles,
    input  logic [HP_WD-1:0]    half_period,
    output logic                pulse_p,
    output logic                pulse_n,
    output logic                pulse_clamp,
    output logic                tx_en,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int unsigned LUT_DEPTH = 1 << ADDR_WD;

`ifdef TX_DAMP_EN
    typedef enum logic [2:0] {IDLE, FETCH, DLY, POS, NEG, DAMP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, DLY, POS, NEG} state_t;
`endif

    state_t state, nxt;

    logic [DELAY_WD-1:0] lut [LUT_DEPTH];
    logic [DELAY_WD-1:0] lut_q;
    logic [DELAY_WD-1:0] dly_cnt;
    logic [HP_WD-1:0]    hp_len;
    logic [HP_WD-1:0]    hp_cnt;
    logic [CYC_WD-1:0]   cyc_cnt;

    logic accept;
    logic phase_entry;
    logic p_d, n_d, clamp_d, en_d, busy_d, done_d;

    assign accept = (state == IDLE) && tx_start;

    // Delay LUT: not reset; read on fire acceptance sees the pre-write value on a collision
    always_ff @(posedge clk) begin
        if (lut_we) lut[lut_addr] <= lut_din;
        if (accept) lut_q <= lut[line_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (state != IDLE && tx_abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (tx_start) nxt = FETCH;
                FETCH: nxt = (lut_q == '0) ? POS : DLY;
                DLY:   if (dly_cnt == DELAY_WD'(1)) nxt = POS;
                POS:   if (hp_cnt == '0) nxt = NEG;
                NEG: begin
                    if (hp_cnt == '0) begin
`ifdef TX_DAMP_EN
                        nxt = (cyc_cnt == CYC_WD'(1)) ? DAMP : POS;
`else
                        nxt = (cyc_cnt == CYC_WD'(1)) ? IDLE : POS;
`endif
                    end
                end
`ifdef TX_DAMP_EN
                DAMP:  if (hp_cnt == '0) nxt = IDLE;
`endif
                default: nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state
    always_comb begin
        p_d         = (nxt == POS);
        n_d         = (nxt == NEG);
        clamp_d     = 1'b0;
        phase_entry = (nxt != state) && (nxt == POS || nxt == NEG);
`ifdef TX_DAMP_EN
        clamp_d     = (nxt == DAMP);
        phase_entry = (nxt != state) && (nxt == POS || nxt == NEG || nxt == DAMP);
`endif
        en_d        = (nxt != IDLE);
        busy_d      = (nxt != IDLE);
        done_d      = (state != IDLE) && (nxt == IDLE) && !tx_abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_p     <= 1'b0;
            pulse_n     <= 1'b0;
            pulse_clamp <= 1'b0;
            tx_en       <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            pulse_p     <= p_d;
            pulse_n     <= n_d;
            pulse_clamp <= clamp_d;
            tx_en       <= en_d;
            tx_busy     <= busy_d;
            tx_done     <= done_d;
        end
    end

    // Burst parameters latched at acceptance; zero lengths are promoted to one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt <= '0;
            hp_len  <= '0;
            hp_cnt  <= '0;
            cyc_cnt <= '0;
        end else begin
            if (accept) begin
                hp_len  <= (half_period == '0) ? '0 : half_period - HP_WD'(1);
                cyc_cnt <= (num_cycles == '0) ? CYC_WD'(1) : num_cycles;
            end else if (state == NEG && nxt == POS) begin
                cyc_cnt <= cyc_cnt - CYC_WD'(1);
            end

            if (state == FETCH)    dly_cnt <= lut_q;
            else if (state == DLY) dly_cnt <= dly_cnt - DELAY_WD'(1);

            if (phase_entry)        hp_cnt <= hp_len;
            else if (hp_cnt != '0)  hp_cnt <= hp_cnt - HP_WD'(1);
        end
    end

endmodule

// File: tb/tb_tx_pulse_ch.sv
// Directed self-checking bench for tx_pulse_ch; expectations follow TX_DAMP_EN when defined.
`timescale 1ns/1ps
module tb_tx_pulse_ch;

    localparam int unsigned ADDR_WD  = 7;
    localparam int unsigned DELAY_WD = 12;
    localparam int unsigned CYC_WD   = 4;
    localparam int unsigned HP_WD    = 6;
`ifdef TX_DAMP_EN
    localparam bit DAMP = 1'b1;
`else
    localparam bit DAMP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [ADDR_WD-1:0]  lut_addr;
    logic                lut_we;
    logic [DELAY_WD-1:0] lut_din;
    logic [ADDR_WD-1:0]  line_sel;
    logic                tx_start;
    logic                tx_abort;
    logic [CYC_WD-1:0]   num_cycles;
    logic [HP_WD-1:0]    half_period;
    logic pulse_p, pulse_n, pulse_clamp, tx_en, tx_busy, tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int e     = 0;

    always #5 clk = ~clk;

    tx_pulse_ch #(.ADDR_WD(ADDR_WD), .DELAY_WD(DELAY_WD), .CYC_WD(CYC_WD), .HP_WD(HP_WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
        .line_sel(line_sel), .tx_start(tx_start), .tx_abort(tx_abort),
        .num_cycles(num_cycles), .half_period(half_period),
        .pulse_p(pulse_p), .pulse_n(pulse_n), .pulse_clamp(pulse_clamp),
        .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at E%0d: observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic lut_write(input logic [ADDR_WD-1:0] a, input logic [DELAY_WD-1:0] d);
        lut_addr = a; lut_din = d; lut_we = 1'b1;
        step();
        lut_we = 1'b0;
    endtask

    // Fire: the edge that samples tx_start becomes E0; inputs are scrambled afterwards
    task automatic fire(input logic [ADDR_WD-1:0] line, input logic [CYC_WD-1:0] nc,
                        input logic [HP_WD-1:0] hp);
        line_sel = line; num_cycles = nc; half_period = hp; tx_start = 1'b1;
        step();
        e = 0;
        tx_start = 1'b0; lut_we = 1'b0;
        line_sel = ADDR_WD'($urandom); num_cycles = '1; half_period = '1;
    endtask

    function automatic int burst_end(input int d, input int n, input int h);
        return 1 + d + 2 * n * h + (DAMP ? h : 0);
    endfunction

    // Expected outputs after edge e for delay d, n cycles, half-period h
    task automatic check_edge(input int d, input int n, input int h);
        int  t, fin;
        logic xp, xn, xc;
        t   = e - 1 - d;
        fin = burst_end(d, n, h);
        xp  = (t >= 0) && (t < 2 * n * h) && (((t / h) % 2) == 0);
        xn  = (t >= 0) && (t < 2 * n * h) && (((t / h) % 2) == 1);
        xc  = DAMP && (t >= 2 * n * h) && (t < 2 * n * h + h);
        chk("pulse_p", pulse_p, xp);
        chk("pulse_n", pulse_n, xn);
        chk("pulse_clamp", pulse_clamp, xc);
        chk("tx_en", tx_en, (e >= 0) && (e < fin));
        chk("tx_busy", tx_busy, (e >= 0) && (e < fin));
        chk("tx_done", tx_done, e == fin);
    endtask

    task automatic follow(input int d, input int n, input int h);
        int fin;
        fin = burst_end(d, n, h);
        forever begin
            check_edge(d, n, h);
            if (e >= fin + 1) break;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; lut_addr = '0; lut_we = 1'b0; lut_din = '0; line_sel = '0;
        tx_start = 1'b0; tx_abort = 1'b0; num_cycles = '0; half_period = '0;
        repeat (3) step();
        chk("rst_pulse_p", pulse_p, 1'b0);
        chk("rst_pulse_n", pulse_n, 1'b0);
        chk("rst_clamp", pulse_clamp, 1'b0);
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        lut_write(7'd3, 12'd5);
        lut_write(7'd0, 12'd0);
        lut_write(7'd7, 12'd1);

        // Normal burst: D=5, N=2, H=4
        fire(7'd3, 4'd2, 6'd4);
        follow(5, 2, 4);

        // Minimum burst: zero delay, zero cycles/half-period promoted to one
        fire(7'd0, 4'd0, 6'd0);
        follow(0, 1, 1);

        // Delay of one, three cycles, half-period two
        fire(7'd7, 4'd3, 6'd2);
        follow(1, 3, 2);

        // Busy start ignored (sampled E8), abort sampled E12, new fire sampled E13
        fire(7'd3, 4'd2, 6'd4);
        while (e < 11) begin
            check_edge(5, 2, 4);
            tx_start = (e == 7);
            if (e == 7) begin
                line_sel = 7'd0; num_cycles = 4'd1; half_period = 6'd1;
            end
            step();
        end
        tx_start = 1'b0;
        check_edge(5, 2, 4);
        tx_abort = 1'b1;
        step();
        tx_abort = 1'b0;
        chk("abort_pulse_p", pulse_p, 1'b0);
        chk("abort_pulse_n", pulse_n, 1'b0);
        chk("abort_clamp", pulse_clamp, 1'b0);
        chk("abort_tx_en", tx_en, 1'b0);
        chk("abort_tx_busy", tx_busy, 1'b0);
        chk("abort_no_done", tx_done, 1'b0);
        fire(7'd0, 4'd0, 6'd0);
        follow(0, 1, 1);

        // Collision: write LUT[3]=9 on the same edge that fires line 3
        lut_addr = 7'd3; lut_din = 12'd9; lut_we = 1'b1;
        fire(7'd3, 4'd1, 6'd1);
        follow(5, 1, 1);
        fire(7'd3, 4'd1, 6'd1);
        follow(9, 1, 1);

        // Asynchronous reset during POS (D=9, H=2: POS at E10-E11)
        fire(7'd3, 4'd1, 6'd2);
        while (e < 10) begin
            check_edge(9, 1, 2);
            step();
        end
        check_edge(9, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pulse_p", pulse_p, 1'b0);
        chk("arst_tx_en", tx_en, 1'b0);
        chk("arst_tx_busy", tx_busy, 1'b0);
        chk("arst_tx_done", tx_done, 1'b0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // LUT survives reset
        fire(7'd7, 4'd1, 6'd1);
        follow(1, 1, 1);
        fire(7'd3, 4'd1, 6'd1);
        follow(9, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
